// File: rtl/vga_timing_gen_if.sv
// VGA raster bundle passed along the draw-stage chain.
// The generator drives it through the out modport; each consumer reads it through the in modport.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (
      output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );

   modport in (
      input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster source: h/v counters with sync/blank flags and line/frame strobes.
// Flags are decoded from the next-count values, so they line up with the counts presented in the same cycle.
module vga_timing_gen #(
   parameter int HOR_ACTIVE = 1024,
   parameter int HOR_FP     = 24,
   parameter int HOR_SYNC   = 136,
   parameter int HOR_BP     = 160,
   parameter int VER_ACTIVE = 768,
   parameter int VER_FP     = 3,
   parameter int VER_SYNC   = 6,
   parameter int VER_BP     = 29
) (
   input  logic clk60MHz,
   input  logic rst_n,
   input  logic en,
   output logic line_start,
   output logic frame_start,
   vga_if.out   out
);

   localparam int HOR_TOTAL = HOR_ACTIVE + HOR_FP + HOR_SYNC + HOR_BP;
   localparam int VER_TOTAL = VER_ACTIVE + VER_FP + VER_SYNC + VER_BP;

   generate
      if (HOR_TOTAL > 2048 || VER_TOTAL > 2048) begin : g_bad_totals
         $error("vga_timing_gen: HOR_TOTAL and VER_TOTAL must not exceed 2048");
      end
   endgenerate

   // Comparisons are done at 12 bits so that a window end of 2048 is still representable.
   localparam logic [11:0] H_LAST       = 12'(HOR_TOTAL - 1);
   localparam logic [11:0] H_BLANK      = 12'(HOR_ACTIVE);
   localparam logic [11:0] H_SYNC_START = 12'(HOR_ACTIVE + HOR_FP);
   localparam logic [11:0] H_SYNC_END   = 12'(HOR_ACTIVE + HOR_FP + HOR_SYNC);
   localparam logic [11:0] V_LAST       = 12'(VER_TOTAL - 1);
   localparam logic [11:0] V_BLANK      = 12'(VER_ACTIVE);
   localparam logic [11:0] V_SYNC_START = 12'(VER_ACTIVE + VER_FP);
   localparam logic [11:0] V_SYNC_END   = 12'(VER_ACTIVE + VER_FP + VER_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [10:0] h_next;
   logic [10:0] v_next;
   logic        h_wrap;
   logic        v_wrap;
   logic        hsync_q;
   logic        vsync_q;
   logic        hblnk_q;
   logic        vblnk_q;

   always_comb begin
      h_wrap = ({1'b0, h_cnt} == H_LAST);
      v_wrap = ({1'b0, v_cnt} == V_LAST);
      h_next = h_wrap ? 11'd0 : h_cnt + 11'd1;
      v_next = v_cnt;
      if (h_wrap) begin
         v_next = v_wrap ? 11'd0 : v_cnt + 11'd1;
      end
   end

   // With en low nothing is written, so counts, flags and strobes all hold.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         hblnk_q     <= 1'b0;
         vblnk_q     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         h_cnt       <= h_next;
         v_cnt       <= v_next;
         hblnk_q     <= ({1'b0, h_next} >= H_BLANK);
         hsync_q     <= ({1'b0, h_next} >= H_SYNC_START) && ({1'b0, h_next} < H_SYNC_END);
         vblnk_q     <= ({1'b0, v_next} >= V_BLANK);
         vsync_q     <= ({1'b0, v_next} >= V_SYNC_START) && ({1'b0, v_next} < V_SYNC_END);
         line_start  <= h_wrap;
         frame_start <= h_wrap && v_wrap;
      end
   end

   assign out.hcount = h_cnt;
   assign out.vcount = v_cnt;
   assign out.hsync  = hsync_q;
   assign out.vsync  = vsync_q;
   assign out.hblnk  = hblnk_q;
   assign out.vblnk  = vblnk_q;
   assign out.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size and a shrunken raster generator are driven in lockstep and checked
// against an arithmetic model derived from the number of enabled cycles since reset.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic        ls;
      logic        fs;
   } obs_t;

   localparam int S_HA = 16, S_HF = 3, S_HS = 5, S_HB = 4;
   localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 4;

   logic clk60MHz = 1'b0;
   logic rst_n    = 1'b0;
   logic en       = 1'b1;
   logic big_ls, big_fs, small_ls, small_fs;

   vga_if big_bus ();
   vga_if small_bus ();

   vga_timing_gen dut_big (
      .clk60MHz    (clk60MHz),
      .rst_n       (rst_n),
      .en          (en),
      .line_start  (big_ls),
      .frame_start (big_fs),
      .out         (big_bus)
   );

   vga_timing_gen #(
      .HOR_ACTIVE (S_HA), .HOR_FP (S_HF), .HOR_SYNC (S_HS), .HOR_BP (S_HB),
      .VER_ACTIVE (S_VA), .VER_FP (S_VF), .VER_SYNC (S_VS), .VER_BP (S_VB)
   ) dut_small (
      .clk60MHz    (clk60MHz),
      .rst_n       (rst_n),
      .en          (en),
      .line_start  (small_ls),
      .frame_start (small_fs),
      .out         (small_bus)
   );

   always #5 clk60MHz = ~clk60MHz;

   obs_t q_big[$];
   obs_t q_small[$];
   int   k = 0;
   int   checks = 0;
   int   errors = 0;
   bit   running = 1'b1;

   // Expected raster for a given count of enabled cycles since reset.
   function automatic obs_t model(input int cyc, input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb);
      obs_t r;
      int ht = ha + hf + hs + hb;
      int vt = va + vf + vs + vb;
      int h  = cyc % ht;
      int v  = (cyc / ht) % vt;
      r.h   = 11'(h);
      r.v   = 11'(v);
      r.hb  = (h >= ha);
      r.hs  = (h >= ha + hf) && (h < ha + hf + hs);
      r.vb  = (v >= va);
      r.vs  = (v >= va + vf) && (v < va + vf + vs);
      r.rgb = 12'h000;
      r.ls  = (cyc > 0) && (h == 0);
      r.fs  = (cyc > 0) && (h == 0) && (v == 0);
      return r;
   endfunction

   task automatic pushExpected();
      q_big.push_back(model(k, 1024, 24, 136, 160, 768, 3, 6, 29));
      q_small.push_back(model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
   endtask

   task automatic checkOutput(input string name, input obs_t exp, input obs_t act);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s t=%0t: actual h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h ls=%b fs=%b, required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h ls=%b fs=%b",
                  name, $time, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.rgb, act.ls, act.fs,
                  exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.rgb, exp.ls, exp.fs);
      end
   endtask

   // Drive en for a number of cycles; en_pct is the chance (in percent) that en is high.
   task automatic applyStimulus(input int cycles, input int en_pct);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk60MHz);
         en = ($urandom_range(99) < en_pct);
      end
   endtask

   // Assert reset between edges; the outputs must clear without a clock edge.
   task automatic asyncReset(input int hold);
      @(negedge clk60MHz);
      #1;
      rst_n = 1'b0;
      k = 0;
      pushExpected();
      applyStimulus(hold, 100);
      @(negedge clk60MHz);
      rst_n = 1'b1;
   endtask

   // Model: one expected sample per clock edge.
   initial begin
      while (running) begin
         @(posedge clk60MHz);
         if (!rst_n) k = 0;
         else if (en) k++;
         pushExpected();
      end
   end

   // Monitor: compares whatever the model has queued shortly after each clock transition.
   initial begin
      obs_t exp;
      obs_t act;
      forever begin
         @(posedge clk60MHz or negedge clk60MHz);
         #2;
         while (q_big.size() > 0) begin
            exp = q_big.pop_front();
            act = {big_bus.hcount, big_bus.vcount, big_bus.hsync, big_bus.vsync,
                   big_bus.hblnk, big_bus.vblnk, big_bus.rgb, big_ls, big_fs};
            checkOutput("big", exp, act);
         end
         while (q_small.size() > 0) begin
            exp = q_small.pop_front();
            act = {small_bus.hcount, small_bus.vcount, small_bus.hsync, small_bus.vsync,
                   small_bus.hblnk, small_bus.vblnk, small_bus.rgb, small_ls, small_fs};
            checkOutput("small", exp, act);
         end
      end
   end

   initial begin
      $display("[TB] start");
      applyStimulus(3, 100);
      @(negedge clk60MHz);
      rst_n = 1'b1;
      applyStimulus(1046, 100);
      applyStimulus(10, 0);
      applyStimulus(2000, 100);
      for (int r = 0; r < 6; r++) begin
         applyStimulus(300 + $urandom_range(400), 85);
         asyncReset(1 + $urandom_range(2));
      end
      applyStimulus(1500, 100);
      running = 1'b0;
      repeat (3) @(negedge clk60MHz);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
